// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg
//   Shared constants for the RAM-backed FIFO controller: address/data widths
//   of the 256x16 dual-port RAM, the entry count and the occupancy counter
//   width. Also holds the per-cycle acceptance struct used inside the
//   controller.
package ram_fifo_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;

  // Which requests were accepted this cycle.
  typedef struct packed {
    logic push_acc;
    logic pop_acc;
  } fifo_acc_t;

endpackage : ram_fifo_pkg

// File: rtl/ram_fifo_ptr.sv
// ram_fifo_ptr
//   Wrapping ADDR_W-bit pointer. Advances by one on each clock where inc is
//   high and wraps from 2**ADDR_W-1 to 0 through natural overflow.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset, pointer -> 0
//   inc  in   advance the pointer on this edge
//   ptr  out  current pointer value
module ram_fifo_ptr #(
  parameter int ADDR_W = ram_fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule : ram_fifo_ptr

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   Pointer and flag controller that turns a 256x16 dual-port RAM with a
//   registered read port into a synchronous FIFO. Drives the RAM write port
//   and read address; the consumer takes data from the RAM dout in the cycle
//   pop_valid is high.
//
// Request semantics (no ready/valid pair on the push/pop side):
//   push is accepted on an edge when push is high and the registered full
//   flag is low; pop is accepted when pop is high and the registered empty
//   flag is low. A rejected request is dropped (and recorded in the sticky
//   overflow/underflow flags), never held. An accepted pop yields pop_valid
//   one cycle later, with the popped word on the RAM dout in that same cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (shared with RAM)
//   push, push_data write request and data
//   pop             read request
//   full, empty     registered, count == DEPTH / count == 0
//   almost_full     registered, count >= AFULL_THRESH
//   almost_empty    registered, count <= AEMPTY_THRESH
//   count           registered occupancy 0..DEPTH
//   pop_valid       RAM dout holds popped data this cycle
//   overflow        sticky, push while full
//   underflow       sticky, pop while empty
//   ram_w_addr, ram_wr, ram_din  RAM write port
//   ram_r_addr      RAM read address (read pointer)
module ram_fifo_ctrl #(
  parameter int ADDR_W        = ram_fifo_pkg::ADDR_W,
  parameter int DATA_W        = ram_fifo_pkg::DATA_W,
  parameter int AFULL_THRESH  = 240,
  parameter int AEMPTY_THRESH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              pop_valid,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_r_addr
);

  import ram_fifo_pkg::*;

  localparam int FDEPTH = 1 << ADDR_W;
  localparam int FCNT_W = ADDR_W + 1;

  fifo_acc_t         acc;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;

  // Acceptance uses only registered flags, so pop never reaches push
  // acceptance combinationally and there is no empty-FIFO bypass.
  always_comb begin
    acc          = '0;
    acc.push_acc = push & ~full;
    acc.pop_acc  = pop & ~empty;
  end

  ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (acc.push_acc),
    .ptr (wr_ptr)
  );

  ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (acc.pop_acc),
    .ptr (rd_ptr)
  );

  // Simultaneous accepted push and pop leave the occupancy unchanged.
  always_comb begin
    count_next = count;
    if (acc.push_acc && !acc.pop_acc) begin
      count_next = count + FCNT_W'(1);
    end else if (acc.pop_acc && !acc.push_acc) begin
      count_next = count - FCNT_W'(1);
    end
  end

  // Flags are computed from count_next so they change on the same edge as
  // count. full/empty never compare pointers, which alias at 0 and DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      pop_valid    <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == FCNT_W'(FDEPTH));
      almost_empty <= (count_next <= FCNT_W'(AEMPTY_THRESH));
      almost_full  <= (count_next >= FCNT_W'(AFULL_THRESH));
      // The RAM registers mem[rd_ptr] on the same edge rd_ptr advances, so
      // a single flop aligns pop_valid with its data.
      pop_valid    <= acc.pop_acc;
      overflow     <= overflow  | (push & full);
      underflow    <= underflow | (pop & empty);
    end
  end

  assign ram_w_addr = wr_ptr;
  assign ram_wr     = acc.push_acc;
  assign ram_din    = push_data;
  assign ram_r_addr = rd_ptr;

endmodule : ram_fifo_ctrl
